pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Instruction-fetch stage directly upstream of the controller. Owns the PC, issues word
//   fetches to instruction memory (variable latency, one outstanding request), buffers up to
//   2 fetched words, and presents IM_instruction/PC_data_out with a valid/ready handshake.
//   Accepts the controller's next-PC (PC_data_in) as a redirect that flushes in-flight work.
// PARAMETERS
//   RESET_VECTOR  32'h0040_0000  PC loaded on reset
//   BUF_DEPTH     2              instruction buffer entries (power of 2, >=2)
// PORTS
//   clk             in   1   single clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   imem_req        out  1   fetch request valid
//   imem_addr       out  32  fetch byte address (word aligned)
//   imem_gnt        in   1   request accepted this cycle (imem_req && imem_gnt)
//   imem_rvalid     in   1   read data valid, responses in request order
//   imem_rdata      in   32  fetched instruction word
//   redirect_valid  in   1   controller redirects fetch (branch/jump/sequential commit)
//   PC_data_in      in   32  redirect target PC
//   IM_instruction  out  32  instruction to controller
//   PC_data_out     out  32  PC of IM_instruction
//   inst_valid      out  1   IM_instruction/PC_data_out valid
//   inst_ready      in   1   controller consumes entry (inst_valid && inst_ready)
// BEHAVIOUR
//   Reset: fetch_pc=RESET_VECTOR, buffer empty, drop_cnt=0, FSM=S_IDLE; imem_req=0,
//     imem_addr=RESET_VECTOR, inst_valid=0, IM_instruction=0, PC_data_out=RESET_VECTOR.
//   FSM: S_IDLE -> S_REQ (1 cycle after reset deassert). S_REQ: imem_req=1,imem_addr=fetch_pc;
//     on gnt -> S_WAIT, fetch_pc+=4. S_WAIT: on rvalid write {pc,rdata} to buffer -> S_REQ if
//     buffer has a free slot after this write, else S_FULL. S_FULL: imem_req=0; when a slot
//     frees (pop) -> S_REQ. A request is issued only if a slot is reserved for its response.
//   Output: inst_valid = buffer non-empty; outputs are head entry, combinational from buffer.
//   Latency: rvalid in cycle N -> inst_valid in cycle N+1 (registered buffer write).
//   Handshake: pop on inst_valid&&inst_ready; head holds stable while inst_ready=0.
//   Redirect (highest priority): buffer flushed same edge, fetch_pc=PC_data_in, FSM->S_REQ;
//     simultaneous pop ignored; if a granted response is outstanding, drop_cnt=1 and that
//     response is discarded; new request may issue next cycle. Redirect during S_REQ with
//     gnt same cycle: granted request counts as outstanding and is dropped.
//   Buffer full with pop and rvalid same cycle: both occur, occupancy unchanged.
//   fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 (modulo 2^32).
//   imem_req/imem_addr held stable until gnt (no withdrawal except on redirect).
//   rst mid-transaction: all state cleared immediately; late rvalid after reset ignored
//     (drop_cnt irrelevant since FSM in S_IDLE does not accept rvalid).
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined: extra out port fetch_misaligned (1); redirect with
//     PC_data_in[1:0]!=0 sets fetch_misaligned=1 (sticky until rst), FSM parks in S_IDLE,
//     no requests issued, inst_valid=0. Undefined: port absent, PC_data_in[1:0] forced to 0.
// STRUCTURE
//   cpu31_pkg: RESET_VECTOR default, INST_NOP (32'h0000_0000), fetch state enum
//     {S_IDLE,S_REQ,S_WAIT,S_FULL}, fetch_entry_t {pc[31:0], inst[31:0]}.
//   Sub-module fetch_buffer: BUF_DEPTH-entry FIFO of fetch_entry_t with push/pop/flush,
//     count, full/empty; pc_fetch_unit holds PC, FSM, drop counter, reservation logic.
// TESTING
//   1 Reset release, imem gnt=1, rvalid 1 cycle later -> first imem_addr=0x0040_0000,
//     inst_valid with PC_data_out=0x0040_0000 one cycle after rvalid; next addr 0x0040_0004.
//   2 inst_ready=0 for 10 cycles -> 2 entries buffered, imem_req=0 (S_FULL), head stable;
//     raise inst_ready -> PCs 0x400000,0x400004,0x400008 delivered in order, no gaps lost.
//   3 Redirect PC_data_in=0x0040_0100 while request outstanding -> stale rvalid dropped,
//     buffer empty next cycle, next imem_addr=0x0040_0100, first valid PC=0x0040_0100.
//   4 Redirect to 0xFFFF_FFFC -> addresses 0xFFFF_FFFC then 0x0000_0000.
//   5 Assert rst mid-S_WAIT, then send rvalid -> outputs at reset values, rvalid ignored.
//   6 FETCH_ALIGN_CHECK_EN: redirect to 0x0040_0102 -> fetch_misaligned=1, imem_req=0.

Source files
------------

// File: rtl/cpu31_pkg.sv
// Shared types and constants for the fetch stage: fetch FSM states, buffer entry layout,
// default reset vector and the NOP encoding presented while nothing has been fetched.
package cpu31_pkg;

  localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0040_0000;
  localparam logic [31:0] INST_NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, inst} entries between instruction memory and the controller.
// Flush wins over push and pop in the same cycle; the head is read combinationally.
module fetch_buffer
  import cpu31_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_VECTOR_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_PC, inst: INST_NOP};
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and buffers words
// for the controller. Optional FETCH_ALIGN_CHECK_EN adds fetch_misaligned and parks on bad targets.
//
// state  | meaning
// S_IDLE | post-reset settle cycle, or parked after a misaligned redirect
// S_REQ  | imem_req high at fetch_pc, waiting for grant
// S_WAIT | request granted, waiting for its rvalid
// S_FULL | buffer full, no slot to reserve for another request
module pc_fetch_unit
  import cpu31_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] PC_data_in,
  output logic [31:0] IM_instruction,
  output logic [31:0] PC_data_out,
  output logic        inst_valid,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_misaligned,
`endif
  input  logic        inst_ready
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [1:0]    drop_cnt, drop_cnt_nxt;
  logic [1:0]    inflight;
  logic [31:0]   redirect_pc;
  logic          misaligned_redirect;
  logic          parked;
  logic          acc_gnt;
  logic          rsp_take;
  logic          buf_push, buf_pop, buf_flush;
  logic          buf_full, buf_empty;
  logic [CW-1:0] buf_count;
  fetch_entry_t  buf_head;
  fetch_entry_t  buf_wr;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q;

  assign redirect_pc         = PC_data_in;
  assign misaligned_redirect = redirect_valid && (PC_data_in[1:0] != 2'b00);
  assign parked              = misaligned_q;
  assign fetch_misaligned    = misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else if (misaligned_redirect) begin
      misaligned_q <= 1'b1;
    end
  end
`else
  assign redirect_pc         = PC_data_in & 32'hFFFF_FFFC;
  assign misaligned_redirect = 1'b0;
  assign parked              = 1'b0;
`endif

  assign acc_gnt  = imem_req && imem_gnt;
  // A response belongs to us only while something is in flight; late beats after reset are ignored.
  assign rsp_take = imem_rvalid && ((drop_cnt != 2'd0) || (state == S_WAIT));
  assign inflight = drop_cnt + {1'b0, state == S_WAIT} + {1'b0, acc_gnt} - {1'b0, rsp_take};

  assign imem_addr      = fetch_pc;
  assign inst_valid     = !buf_empty;
  assign IM_instruction = buf_head.inst;
  assign PC_data_out    = buf_head.pc;
  assign buf_wr         = '{pc: fetch_pc - 32'd4, inst: imem_rdata};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_cnt_nxt = drop_cnt;
    imem_req     = 1'b0;
    buf_push     = 1'b0;
    buf_flush    = 1'b0;
    buf_pop      = inst_valid && inst_ready;

    if (rsp_take && (drop_cnt != 2'd0)) begin
      drop_cnt_nxt = drop_cnt - 2'd1;
    end

    case (state)
      S_IDLE: begin
        if (!parked) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Hold off when the drop counter is saturated so it can never overflow.
        imem_req = !buf_full && (drop_cnt != 2'd3);
        if (acc_gnt) begin
          state_nxt    = S_WAIT;
          fetch_pc_nxt = pc_next(fetch_pc);
        end
      end
      S_WAIT: begin
        if (rsp_take && (drop_cnt == 2'd0)) begin
          buf_push = 1'b1;
          if (buf_pop || (buf_count < CW'(BUF_DEPTH - 1))) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (buf_pop) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (redirect_valid) begin
      buf_flush    = 1'b1;
      buf_push     = 1'b0;
      buf_pop      = 1'b0;
      fetch_pc_nxt = redirect_pc;
      drop_cnt_nxt = inflight;
      state_nxt    = (misaligned_redirect || parked) ? S_IDLE : S_REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_VECTOR;
      drop_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  fetch_buffer #(
    .DEPTH    (BUF_DEPTH),
    .RESET_PC (RESET_VECTOR)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .pop      (buf_pop),
    .flush    (buf_flush),
    .wr_entry (buf_wr),
    .head     (buf_head),
    .count    (buf_count),
    .full     (buf_full),
    .empty    (buf_empty)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: an imem responder with programmable latency, a scoreboard
// queue of expected {pc, inst} pairs and a monitor that checks every accepted instruction.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] PC_data_in;
  logic [31:0] IM_instruction, PC_data_out;
  logic        inst_valid, inst_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        gnt_en;
  int          lat;
  int          cyc = 0;
  int          due_q[$];
  logic [31:0] addr_q[$];
  logic [63:0] exp_q[$];
  bit          ok;

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_en;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .PC_data_in     (PC_data_in),
    .IM_instruction (IM_instruction),
    .PC_data_out    (PC_data_out),
    .inst_valid     (inst_valid),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misaligned (fetch_misaligned),
`endif
    .inst_ready     (inst_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // Fixed-latency in-order memory; a grant seen in cycle k answers in cycle k+lat.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        due_q.push_back(cyc + lat);
        addr_q.push_back(imem_addr);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(addr_q[0]);
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h inst %h, nothing expected", PC_data_out, IM_instruction);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", PC_data_out, e[63:32]);
          check("sb_inst", IM_instruction, e[31:0]);
        end
      end
    end
  end

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        got = 1'b1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL grant_timeout: got no grant, required one within 60 cycles");
  endtask

  // Let the controller consume until the scoreboard is empty, then stall it again.
  task automatic drain();
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        inst_ready = 1'b0;
        return;
      end
    end
    inst_ready = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d entries outstanding, required 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    PC_data_in     = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    PC_data_in     = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    PC_data_in     = '0;
    gnt_en         = 1'b1;
    lat            = 1;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RV);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", IM_instruction, 32'h0);
    check("rst_pc", PC_data_out, RV);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_misaligned", fetch_misaligned, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First fetch and one-cycle rvalid-to-valid latency
    wait_grant(ok);
    check("t1_first_addr", imem_addr, RV);
    @(negedge clk);
    check("t1_valid_during_rvalid", inst_valid, 0);
    @(negedge clk);
    check("t1_valid", inst_valid, 1);
    check("t1_pc", PC_data_out, RV);
    check("t1_inst", IM_instruction, mem_word(RV));
    check("t1_next_req", imem_req, 1);
    check("t1_next_addr", imem_addr, RV + 32'd4);

    // Backpressure fills the buffer and stops requests
    repeat (10) @(negedge clk);
    check("t2_full_req", imem_req, 0);
    check("t2_full_valid", inst_valid, 1);
    check("t2_head_stable", PC_data_out, RV);
    expect_pc(RV);
    expect_pc(RV + 32'd4);
    expect_pc(RV + 32'd8);
    drain();

    // Redirect with a granted request outstanding; its late response must vanish
    lat = 3;
    do_redirect(32'h0040_0200);
    wait_grant(ok);
    check("t3_pre_addr", imem_addr, 32'h0040_0200);
    do_redirect(32'h0040_0100);
    @(negedge clk);
    check("t3_flushed", inst_valid, 0);
    check("t3_req", imem_req, 1);
    check("t3_addr", imem_addr, 32'h0040_0100);
    expect_pc(32'h0040_0100);
    expect_pc(32'h0040_0104);
    expect_pc(32'h0040_0108);
    drain();

    // PC wrap at the top of the address space
    lat = 1;
    do_redirect(32'hFFFF_FFFC);
    wait_grant(ok);
    check("t4_addr_top", imem_addr, 32'hFFFF_FFFC);
    wait_grant(ok);
    check("t4_addr_wrap", imem_addr, 32'h0000_0000);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    drain();

    // Reset while waiting on a response; the late beat must be ignored
    lat = 3;
    do_redirect(32'h0040_0300);
    wait_grant(ok);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_req", imem_req, 0);
    check("t5_addr", imem_addr, RV);
    check("t5_valid", inst_valid, 0);
    check("t5_inst", IM_instruction, 32'h0);
    check("t5_pc", PC_data_out, RV);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_pc(RV);
    drain();

    // Misaligned redirect target
    lat = 1;
    do_redirect(32'h0040_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (5) @(negedge clk);
    check("t6_misaligned", fetch_misaligned, 1);
    check("t6_req", imem_req, 0);
    check("t6_valid", inst_valid, 0);
`else
    wait_grant(ok);
    check("t6_aligned_addr", imem_addr, 32'h0040_0100);
    expect_pc(32'h0040_0100);
    drain();
`endif

    repeat (5) @(negedge clk);
    check("sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
